muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
// Carries the operation request, the abort, the stall request and the HI/LO write port.
// The pipeline drives the request side; the unit drives the status and write side.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi_we, lo_we, hi_wdata, lo_wdata
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO sequencer writing the HI/LO registers.
// Latency: mul/div write 34 cycles after acceptance, moves write 1 cycle after acceptance.
// Backpressure: busy stalls the pipeline; start is ignored unless idle, flush aborts CALC/FIX.
module muldiv_ctrl #(
    parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIX   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;        // original dividend, written to HI on divide-by-zero
    logic [31:0] opnd_q;     // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_hi_q;   // product high half / partial remainder
    logic [31:0] acc_lo_q;   // multiplier shifting out / quotient shifting in
    logic        neg_q;      // negate product or quotient in FIX
    logic        rem_neg_q;  // negate remainder in FIX
    logic        div0_q;
    logic [31:0] hi_wdata_q, lo_wdata_q;

    // Acceptance decode: flush always wins over a coincident start.
    logic accept, accept_md, accept_mv;
    assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
    assign accept_md = accept && !bus.op[2];
    assign accept_mv = accept && bus.op[2] && !bus.op[1];

    // Operand magnitudes for the signed ops; unsigned ops pass straight through.
    logic        signed_op, a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    assign signed_op = !bus.op[0];
    assign a_neg     = signed_op && bus.a[31];
    assign b_neg     = signed_op && bus.b[31];
    assign mag_a     = a_neg ? (~bus.a + 32'd1) : bus.a;
    assign mag_b     = b_neg ? (~bus.b + 32'd1) : bus.b;

    logic is_div;
    assign is_div = op_q[1];

    // One shift-add step: conditionally add the multiplicand, then shift the 65-bit sum right.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

    // One restoring-divide step: shift the next dividend bit into the remainder and try to subtract.
    logic [32:0] rem_sh, rem_diff;
    logic        rem_ge;
    assign rem_sh   = {acc_hi_q, acc_lo_q[31]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});

    // Sign fix-up and result selection applied while in FIX.
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix, fix_hi, fix_lo;
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
    assign quo_fix  = neg_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    assign rem_fix  = rem_neg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

    // Pick HI/LO write data for the completed mul/div, including the divide-by-zero values.
    always_comb begin
        fix_hi = prod_fix[63:32];
        fix_lo = prod_fix[31:0];
        if (is_div) begin
            if (div0_q) begin
                fix_hi = a_q;
                fix_lo = DIV0_LO;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: CALC runs 32 counted cycles, FIX and WRITE one cycle each.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_md)      state_d = S_CALC;
                else if (accept_mv) state_d = S_WRITE;
            end
            S_CALC: begin
                if (bus.flush)             state_d = S_IDLE;
                else if (cnt_q == 5'd31)   state_d = S_FIX;
            end
            S_FIX: begin
                if (bus.flush) state_d = S_IDLE;
                else           state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch at acceptance and the per-cycle multiply/divide iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 5'd0;
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            opnd_q    <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (accept_md) begin
            cnt_q     <= 5'd0;
            op_q      <= bus.op;
            a_q       <= bus.a;
            opnd_q    <= bus.op[1] ? mag_b : mag_a;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= bus.op[1] ? mag_a : mag_b;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= bus.op[1] && (bus.b == 32'd0);
        end else if (accept_mv) begin
            op_q      <= bus.op;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + 5'd1;
            if (is_div) begin
                acc_hi_q <= rem_ge ? rem_diff[31:0] : rem_sh[31:0];
                acc_lo_q <= {acc_lo_q[30:0], rem_ge};
            end else begin
                acc_hi_q <= mul_sum[32:1];
                acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
            end
        end
    end

    // Write-data registers: loaded on entry to WRITE, otherwise hold the last written value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_wdata_q <= 32'd0;
            lo_wdata_q <= 32'd0;
        end else if (accept_mv) begin
            if (bus.op == OP_MTHI) hi_wdata_q <= bus.a;
            else                   lo_wdata_q <= bus.a;
        end else if ((state_q == S_FIX) && !bus.flush) begin
            hi_wdata_q <= fix_hi;
            lo_wdata_q <= fix_lo;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_WRITE);
    assign bus.hi_we    = (state_q == S_WRITE) && (op_q != OP_MTLO);
    assign bus.lo_we    = (state_q == S_WRITE) && (op_q != OP_MTHI);
    assign bus.hi_wdata = hi_wdata_q;
    assign bus.lo_wdata = lo_wdata_q;

endmodule
